// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int LEN_W      = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    // Byte address of word idx; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [LEN_W-1:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is a registered
// one-cycle pulse in the cycle after the lane-3 byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [1:0]  lane,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LANE_LAST = 2'(WORD_BYTES - 1);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            lane_d = 2'd0;
        end else if (byte_valid) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {byte_in, shift_q[23:8]};
            // The newest byte lands on top, so the first byte of the word ends up in [7:0].
            if (lane_q == LANE_LAST) begin
                word_valid_d = 1'b1;
                word_d       = {byte_in, shift_q};
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            lane_q       <= 2'd0;
            shift_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign lane       = lane_q;
    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame, writes it
// into instruction memory from BASE_ADDR and releases core_hold once it checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        restart,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte moves on every rising edge where rx_valid && rx_ready are both
    // high; rx_ready is registered and depends only on state, never on rx_valid.

    state_e             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]         xor_q, xor_d;
    logic               rx_ready_q, rx_ready_d;
    logic               core_hold_q, core_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               fire;
    logic [LEN_W-1:0]   len_rx;
    logic [1:0]         lane;
    logic               word_valid;
    logic [31:0]        word;

    assign fire   = rx_valid && rx_ready_q;
    assign len_rx = {rx_data, len_lo_q};

    byte_packer u_packer (
        .clk        (clk),
        .areset     (areset),
        .clear      (state_q == ST_LEN_HI),
        .byte_valid (fire && (state_q == ST_DATA)),
        .byte_in    (rx_data),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        if (word_valid) begin
            idx_d = idx_q + 16'd1;
        end
        case (state_q)
            ST_IDLE: state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (fire) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                idx_d = '0;
                xor_d = 8'd0;
                if (fire) begin
                    n_d = len_rx;
                    if (len_rx == '0) begin
                        state_d = ST_CSUM;
                    end else if (len_rx > LEN_W'(MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    xor_d = xor_q ^ rx_data;
                    // Earlier words were written at least three cycles ago, so idx_q
                    // already counts them when the final byte arrives.
                    if ((lane == 2'd3) && (idx_q == n_q - 16'd1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (fire) begin
                    state_d = (rx_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                      (state_d == ST_DATA)   || (state_d == ST_CSUM);
        core_hold_d = (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= 8'd0;
            n_q         <= '0;
            idx_q       <= '0;
            xor_q       <= 8'd0;
            rx_ready_q  <= 1'b0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            rx_ready_q  <= rx_ready_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign im_we     = word_valid;
    assign im_addr   = word_addr(BASE_ADDR, idx_q);
    assign im_wdata  = word;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
